// File: rtl/insertion_pixel_feeder_if.sv
// Handshake bundle of the insertion pixel feeder.
// Carries the pixel, watermark and neighbourhood streams.
interface insertion_pixel_feeder_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] wm_in;
  logic       wm_valid;
  logic       wm_ready;
  logic [7:0] Data1;
  logic [7:0] Data2;
  logic [7:0] Data3;
  logic [7:0] Data4;
  logic [1:0] WM_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output pix_in, pix_valid,
    output wm_in, wm_valid,
    output out_ready,
    input  pix_ready, wm_ready,
    input  Data1, Data2, Data3, Data4,
    input  WM_data, out_valid
  );

  modport slave (
    input  pix_in, pix_valid,
    input  wm_in, wm_valid,
    input  out_ready,
    output pix_ready, wm_ready,
    output Data1, Data2, Data3, Data4,
    output WM_data, out_valid
  );
endinterface

// File: rtl/insertion_pixel_feeder.sv
// Builds 4-pixel neighbourhoods plus 2-bit watermark symbols from a raster stream.
// ZERO_BORDER_EN: out-of-image neighbours read as 0 instead of replicated.
module insertion_pixel_feeder #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  insertion_pixel_feeder_if.slave bus,
  output logic busy,
  output logic frame_done
);
  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [7:0]    wm_sr_q;
  logic [2:0]    cnt_q;
  logic [7:0]    left_q;
  logic [7:0]    ul_q;
  logic [7:0]    line_buf [IMG_WIDTH];

  logic [7:0] d1_q, d2_q, d3_q, d4_q;
  logic [1:0] wm_q;
  logic       ov_q;

  logic       run;
  logic       pix_fire;
  logic       wm_fire;
  logic       out_fire;
  logic       last_pix;
  logic       col0;
  logic       row0;
  logic [7:0] up;
  logic [7:0] n_left;
  logic [7:0] n_up;
  logic [7:0] n_ul;

  assign run      = (state_q == RUN);
  assign out_fire = ov_q && bus.out_ready;
  assign col0     = (col_q == '0);
  assign row0     = (row_q == '0);
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign up       = line_buf[col_q];

  assign bus.pix_ready = run && (cnt_q != 3'd0)
                      && (!ov_q || bus.out_ready);
  assign pix_fire      = bus.pix_valid && bus.pix_ready;
  assign bus.wm_ready  = run && ((cnt_q == 3'd0)
                      || ((cnt_q == 3'd1) && pix_fire));
  assign wm_fire       = bus.wm_valid && bus.wm_ready;

  assign busy       = run;
  assign frame_done = (state_q == FLUSH) && out_fire;

  assign bus.Data1     = d1_q;
  assign bus.Data2     = d2_q;
  assign bus.Data3     = d3_q;
  assign bus.Data4     = d4_q;
  assign bus.WM_data   = wm_q;
  assign bus.out_valid = ov_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pix_fire && last_pix) state_d = FLUSH;
      FLUSH:   if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row rule sees the column-adjusted left value.
  always_comb begin
    n_left = left_q;
    n_up   = up;
    n_ul   = ul_q;
`ifdef ZERO_BORDER_EN
    if (col0) begin
      n_left = '0;
      n_ul   = '0;
    end
    if (row0) begin
      n_up = '0;
      n_ul = '0;
    end
`else
    if (col0) begin
      n_left = bus.pix_in;
      n_ul   = up;
    end
    if (row0) begin
      n_up = bus.pix_in;
      n_ul = n_left;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wm_sr_q <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      ul_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      wm_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        col_q   <= '0;
        row_q   <= '0;
        wm_sr_q <= '0;
        cnt_q   <= '0;
        left_q  <= '0;
        ul_q    <= '0;
      end
      // A byte landing with the last symbol's pixel replaces it whole.
      if (wm_fire) begin
        wm_sr_q <= bus.wm_in;
        cnt_q   <= 3'd4;
      end else if (pix_fire) begin
        wm_sr_q <= {wm_sr_q[5:0], 2'b00};
        cnt_q   <= cnt_q - 3'd1;
      end
      if (pix_fire) begin
        left_q <= bus.pix_in;
        ul_q   <= up;
        d1_q   <= bus.pix_in;
        d2_q   <= n_left;
        d3_q   <= n_up;
        d4_q   <= n_ul;
        wm_q   <= wm_sr_q[7:6];
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q != ROW_LAST) row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (pix_fire) ov_q <= 1'b1;
      else if (out_fire) ov_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_fire) line_buf[col_q] <= bus.pix_in;
  end
endmodule

// File: tb/tb_insertion_pixel_feeder.sv
// Scoreboard bench for insertion_pixel_feeder on a 4x2 frame.
// Expected neighbourhoods are hand-computed per border mode.
module tb_insertion_pixel_feeder;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [7:0] d4;
    logic [1:0] wm;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  insertion_pixel_feeder_if bus ();

  insertion_pixel_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   fd_cnt = 0;
  exp_t sb[$];
  int   pix_log[$];
  int   wm_log[$];
  logic [7:0] pix_vals [NPIX];
  exp_t frame_exp [NPIX];
  logic        hold = 1'b0;
  logic [33:0] prev = '0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [33:0] cur;
    exp_t e;
    cur = {bus.Data1, bus.Data2, bus.Data3, bus.Data4, bus.WM_data};
    if (bus.pix_valid && bus.pix_ready) pix_log.push_back(cyc);
    if (bus.wm_valid && bus.wm_ready) wm_log.push_back(cyc);
    if (frame_done) fd_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h, none expected", cur);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(cur), 64'({e.d1, e.d2, e.d3, e.d4, e.wm}));
        check("frame_done", 64'(frame_done), 64'(e.last));
      end
    end else begin
      check("frame_done_spurious", 64'(frame_done), 64'(0));
    end
    if (hold) check("stall_hold", 64'(cur), 64'(prev));
    if (bus.out_valid && !bus.out_ready)
      check("stall_pix_ready", 64'(bus.pix_ready), 64'(0));
    hold = bus.out_valid && !bus.out_ready && !rst;
    prev = cur;
  end

  task automatic check_zero(input string nm);
    check({nm, "_ctrl"},
          64'({bus.out_valid, bus.pix_ready, bus.wm_ready, busy, frame_done}),
          64'(0));
    check({nm, "_data"},
          64'({bus.Data1, bus.Data2, bus.Data3, bus.Data4, bus.WM_data}),
          64'(0));
  endtask

  task automatic send_pix(input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      int t;
      got = 1'b0;
      t   = 0;
      bus.pix_valid = 1'b1;
      bus.pix_in    = pix_vals[i];
      while (!got && t < 200) begin
        @(negedge clk);
        got = bus.pix_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!got) check("pix_timeout", 64'(got), 64'(1));
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic send_wm(input logic [7:0] b, input int gap);
    bit got;
    int t;
    got = 1'b0;
    t   = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.wm_valid = 1'b1;
    bus.wm_in    = b;
    while (!got && t < 200) begin
      @(negedge clk);
      got = bus.wm_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!got) check("wm_timeout", 64'(got), 64'(1));
    bus.wm_valid = 1'b0;
  endtask

  task automatic run_frame(input int npix, input int gap);
    for (int i = 0; i < npix; i++) sb.push_back(frame_exp[i]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    fork
      send_pix(npix);
      begin
        send_wm(8'b00011011, 0);
        send_wm(8'b11100100, gap);
      end
    join
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy || bus.out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({nm, "_drain"}, 64'(sb.size()), 64'(0));
    check({nm, "_idle"},
          64'({busy, bus.out_valid, bus.pix_ready, bus.wm_ready}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int t;
    for (int i = 0; i < NPIX; i++) pix_vals[i] = 8'(10 * (i + 1));
`ifdef ZERO_BORDER_EN
    frame_exp[0] = {8'd10, 8'd0,  8'd0,  8'd0,  2'b00, 1'b0};
    frame_exp[1] = {8'd20, 8'd10, 8'd0,  8'd0,  2'b01, 1'b0};
    frame_exp[2] = {8'd30, 8'd20, 8'd0,  8'd0,  2'b10, 1'b0};
    frame_exp[3] = {8'd40, 8'd30, 8'd0,  8'd0,  2'b11, 1'b0};
    frame_exp[4] = {8'd50, 8'd0,  8'd10, 8'd0,  2'b11, 1'b0};
`else
    frame_exp[0] = {8'd10, 8'd10, 8'd10, 8'd10, 2'b00, 1'b0};
    frame_exp[1] = {8'd20, 8'd10, 8'd20, 8'd10, 2'b01, 1'b0};
    frame_exp[2] = {8'd30, 8'd20, 8'd30, 8'd20, 2'b10, 1'b0};
    frame_exp[3] = {8'd40, 8'd30, 8'd40, 8'd30, 2'b11, 1'b0};
    frame_exp[4] = {8'd50, 8'd50, 8'd10, 8'd10, 2'b11, 1'b0};
`endif
    frame_exp[5] = {8'd60, 8'd50, 8'd20, 8'd10, 2'b10, 1'b0};
    frame_exp[6] = {8'd70, 8'd60, 8'd30, 8'd20, 2'b01, 1'b0};
    frame_exp[7] = {8'd80, 8'd70, 8'd40, 8'd30, 2'b00, 1'b1};

    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.wm_valid  = 1'b0;
    bus.wm_in     = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("idle");

    fd0 = fd_cnt;
    run_frame(NPIX, 0);
    drain("basic");
    check("basic_done_count", 64'(fd_cnt - fd0), 64'(1));

    fd0 = fd_cnt;
    fork
      run_frame(NPIX, 0);
      begin
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!(bus.out_valid && bus.Data1 == 8'd30) && t < 100);
        check("stall_reached", 64'(bus.Data1), 64'(30));
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_done_count", 64'(fd_cnt - fd0), 64'(1));

    pix_log.delete();
    wm_log.delete();
    run_frame(NPIX, 6);
    drain("wm_gap");
    check("wm_gap_pix_count", 64'(pix_log.size()), 64'(NPIX));
    check("wm_gap_wm_count", 64'(wm_log.size()), 64'(2));
    if (pix_log.size() == NPIX && wm_log.size() == 2) begin
      check("wm_first_pix", 64'(pix_log[0] - wm_log[0]), 64'(1));
      check("wm_burst4", 64'(pix_log[3] - pix_log[0]), 64'(3));
      check("wm_resume", 64'(pix_log[4] - wm_log[1]), 64'(1));
    end

    run_frame(5, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midframe_reset");
    check("reset_outputs_seen", 64'(sb.size()), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    fd0 = fd_cnt;
    run_frame(NPIX, 0);
    drain("after_reset");
    check("after_reset_done_count", 64'(fd_cnt - fd0), 64'(1));

    fd0 = fd_cnt;
    fork
      run_frame(NPIX, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    drain("start_in_run");
    check("start_in_run_done_count", 64'(fd_cnt - fd0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/insertion_pixel_feeder.md
Name: insertion_pixel_feeder

Overview:
- Upstream stage of the watermark insertion datapath.
- Accepts a raster-order 8-bit pixel stream and a watermark byte stream.
- For every image pixel, presents one 4-pixel neighbourhood and one 2-bit watermark symbol to the insertion stage:
  - Data1 = current, Data2 = left, Data3 = up, Data4 = up-left.
- Holds one image line in an internal buffer. Pixel and watermark inputs, and the output, use valid/ready handshakes.

Parameters:
IMG_WIDTH, 256, pixels per line (>=2)
IMG_HEIGHT, 256, lines per frame (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle frame start pulse, honoured only in IDLE
pix_in  input  8  image pixel, raster order
pix_valid  input  1  pix_in valid
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
wm_in  input  8  watermark byte, 4 symbols, bits[7:6] used first
wm_valid  input  1  wm_in valid
wm_ready  output  1  byte accepted when wm_valid && wm_ready
Data1  output  8  current pixel
Data2  output  8  left neighbour
Data3  output  8  up neighbour
Data4  output  8  up-left neighbour
WM_data  output  2  watermark symbol paired with this pixel
out_valid  output  1  Data1..4/WM_data valid; drives insertion start
out_ready  input  1  downstream accepts when out_valid && out_ready
busy  output  1  high in RUN
frame_done  output  1  one-cycle pulse when last pixel's output is accepted

Behaviour:
- Reset values:
  - All outputs 0 (pix_ready, wm_ready, out_valid, busy and frame_done included).
  - State IDLE; row/col counters 0; symbol count 0.
  - Line buffer contents don't-care.
- Reset mid-frame aborts the frame. Buffered pixels and symbols are discarded.
- State machine:
  - IDLE -> RUN on start. Clears row/col, symbol count and the up-left register.
  - RUN -> FLUSH when pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.
  - FLUSH -> IDLE when that final output is accepted; frame_done pulses in the same cycle.
  - start outside IDLE is ignored.
- Watermark buffer:
  - 8-bit shift register plus 3-bit symbol count (0..4).
  - wm_ready = (state==RUN) && (count==0 || (count==1 && pixel accepted this cycle)).
  - On byte accept, count = 4.
  - Each pixel accept consumes bits[7:6], shifts left by 2, and decrements count.
- Pixel handshake:
  - pix_ready = (state==RUN) && count!=0 && (!out_valid || out_ready).
  - The block never accepts a pixel without a symbol available.
- Output register, latency 1:
  - A pixel accepted in cycle N drives Data1..4/WM_data with out_valid=1 in cycle N+1.
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid clears after accept unless a new pixel is accepted in the same cycle (back-to-back throughput: 1 pixel/cycle).
- Line buffer:
  - IMG_WIDTH x 8 array indexed by col.
  - On pixel accept, read the old entry (up) and write pix_in in the same cycle (read-before-write).
  - Left register holds the previous accepted pixel.
  - Up-left register holds the previous up value.
- Borders (replicate):
  - col 0: Data2 = Data1, Data4 = Data3.
  - row 0: Data3 = Data1, Data4 = Data2 (applied after the column rule), so at (0,0) all four equal the pixel.
- Counters:
  - col wraps IMG_WIDTH-1 -> 0 with row+1.
  - row never exceeds IMG_HEIGHT-1.
- Simultaneous events:
  - wm byte accept and pixel accept in the same cycle (count==1): the pixel takes the old symbol; count becomes 4 with the new byte.
  - out_ready with new pixel accept: output reloads, no bubble.
- Leftover symbols at frame end are kept until the next start clears them.

Optional Feature:
- Macro: ZERO_BORDER_EN.
- Defined: out-of-image neighbours are driven as 8'h00 instead of replicated.
  - col 0: Data2 = Data4 = 0.
  - row 0: Data3 = Data4 = 0.
- Undefined: replicate rules above.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2; pixels 10,20,30,40,50,60,70,80; wm byte 8'b00011011 then 8'b11100100; out_ready=1. Required outputs:
  - out 1: (10,10,10,10), WM 00.
  - out 2: (20,10,20,10), WM 01.
  - out 5: (50,50,10,10).
  - out 6: (60,50,20,10), WM 10.
  - frame_done after out 8.
- Same frame with out_ready low for 3 cycles at output 3 -> Data1=30 held stable; pix_ready=0 during the stall; no pixel lost or duplicated.
- wm_valid withheld after the first byte -> pix_ready drops after 4 pixels and resumes one cycle after the byte is accepted.
- rst asserted after 5 pixels -> all outputs 0 next cycle; a new start with fresh data reproduces scenario 1 exactly.
- start pulsed during RUN -> ignored; counters continue; frame_done only after the 8th output.
- With ZERO_BORDER_EN, scenario 1 -> out 1 = (10,0,0,0); out 5 = (50,0,10,0).
